// File: rtl/prn_alloc_ctrl.sv
// Physical register number (PRN) allocation controller.
// Keeps one staged PRN per dispatch lane. Each slot is refilled from the free list,
// lowest PRN first. Requesting lanes are granted all-or-nothing in the same cycle.
// A squash drops every staged PRN and spends one recovery cycle refilling before grants resume.
module prn_alloc_ctrl #(
    parameter int N_WAY     = 3,
    parameter int PRF_SIZE  = 64,
    parameter int PRF_WIDTH = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PRF_SIZE-1:0]          free_list_in,
    input  logic [N_WAY-1:0]             dispatch_req,
    input  logic                         squash,
    output logic [N_WAY*PRF_WIDTH-1:0]   alloc_prn_out,
    output logic [N_WAY-1:0]             alloc_valid_out,
    output logic                         stall_out,
    output logic [1:0]                   staged_count_out
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t                 state_r;
    logic [N_WAY-1:0]       slot_valid_r;
    logic [PRF_WIDTH-1:0]   slot_prn_r [N_WAY];
    logic [PRF_SIZE-1:0]    prev_grant_r;

    logic [N_WAY-1:0]       grant_s;
    logic                   stall_s;
    logic [PRF_SIZE-1:0]    held_s;
    logic [PRF_SIZE-1:0]    grant_mask_s;
    logic [PRF_SIZE-1:0]    cand_s;
    logic [N_WAY-1:0]       next_valid_s;
    logic [PRF_WIDTH-1:0]   next_prn_s [N_WAY];
    logic [1:0]             count_s;

    // One-hot decode of a PRN into a free-list-shaped mask.
    function automatic logic [PRF_SIZE-1:0] prn_onehot(input logic [PRF_WIDTH-1:0] idx);
        return {{(PRF_SIZE-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Lowest set bit of vec; MSB of the result flags that any bit was set.
    function automatic logic [PRF_WIDTH:0] lowest_set(input logic [PRF_SIZE-1:0] vec);
        logic [PRF_WIDTH:0] res;
        res = '0;
        for (int p = PRF_SIZE - 1; p >= 0; p--) begin
            if (vec[p]) begin
                res = {1'b1, PRF_WIDTH'(p)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Grant decision: all requesting lanes must hold a staged PRN, else stall the group.
    always_comb begin
        grant_s = '0;
        stall_s = 1'b0;
        if (reset || squash || (state_r == ST_RECOVER)) begin
            stall_s = |dispatch_req;
        end else if (dispatch_req == {N_WAY{1'b0}}) begin
            stall_s = 1'b0;
        end else if (&(slot_valid_r | ~dispatch_req)) begin
            grant_s = dispatch_req;
        end else begin
            stall_s = 1'b1;
        end
    end

    // Candidate mask: free PRNs, minus PRN 0, minus PRNs still held in a slot, minus last cycle's grants.
    always_comb begin
        held_s       = '0;
        grant_mask_s = '0;
        for (int i = 0; i < N_WAY; i++) begin
            held_s       = held_s | ((slot_valid_r[i] && !grant_s[i]) ? prn_onehot(slot_prn_r[i]) : '0);
            grant_mask_s = grant_mask_s | (grant_s[i] ? prn_onehot(slot_prn_r[i]) : '0);
        end
        cand_s = free_list_in & ~held_s & ~prev_grant_r & {{(PRF_SIZE-1){1'b1}}, 1'b0};
    end

    // Refill: empty or just-granted slots take distinct candidates, lowest PRN to lowest slot.
    always_comb begin
        logic [PRF_SIZE-1:0]  pool_v;
        logic [PRF_WIDTH:0]   pick_v;
        pool_v = cand_s;
        pick_v = '0;
        for (int i = 0; i < N_WAY; i++) begin
            next_valid_s[i] = slot_valid_r[i];
            next_prn_s[i]   = slot_prn_r[i];
            pick_v          = lowest_set(pool_v);
            if (!slot_valid_r[i] || grant_s[i]) begin
                if (pick_v[PRF_WIDTH]) begin
                    next_valid_s[i] = 1'b1;
                    next_prn_s[i]   = pick_v[PRF_WIDTH-1:0];
                    pool_v          = pool_v & ~prn_onehot(pick_v[PRF_WIDTH-1:0]);
                end else begin
                    next_valid_s[i] = 1'b0;
                end
            end else begin
                next_valid_s[i] = slot_valid_r[i];
            end
        end
    end

    // Controller FSM and slot state; reset beats squash, squash beats grant and refill.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_RUN;
            slot_valid_r <= '0;
            prev_grant_r <= '0;
            for (int i = 0; i < N_WAY; i++) begin
                slot_prn_r[i] <= '0;
            end
        end else if (squash) begin
            state_r      <= ST_RECOVER;
            slot_valid_r <= '0;
            prev_grant_r <= '0;
        end else begin
            case (state_r)
                ST_RUN:     state_r <= ST_RUN;
                ST_RECOVER: state_r <= ST_RUN;
                default:    state_r <= ST_RUN;
            endcase
            slot_valid_r <= next_valid_s;
            prev_grant_r <= grant_mask_s;
            for (int i = 0; i < N_WAY; i++) begin
                slot_prn_r[i] <= next_prn_s[i];
            end
        end
    end

    // Number of staged slots, straight from the slot registers.
    always_comb begin
        count_s = 2'd0;
        for (int i = 0; i < N_WAY; i++) begin
            count_s = count_s + 2'(slot_valid_r[i]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_WAY; g++) begin : g_lane
            assign alloc_prn_out[g*PRF_WIDTH +: PRF_WIDTH] = slot_prn_r[g];
        end
    endgenerate

    assign alloc_valid_out  = grant_s;
    assign stall_out        = stall_s;
    assign staged_count_out = count_s;

endmodule

// File: tb/tb_prn_alloc_ctrl.sv
// Bench for prn_alloc_ctrl: directed scenarios plus randomized traffic,
// all compared against a set/queue-based reference model.
module tb_prn_alloc_ctrl;

    localparam int NW = 3;
    localparam int PS = 64;
    localparam int PW = 6;

    logic              clock;
    logic              reset;
    logic [PS-1:0]     free_list_in;
    logic [NW-1:0]     dispatch_req;
    logic              squash;
    logic [NW*PW-1:0]  alloc_prn_out;
    logic [NW-1:0]     alloc_valid_out;
    logic              stall_out;
    logic [1:0]        staged_count_out;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit        mvalid [NW];
    int        mprn   [NW];
    bit [63:0] mprev;
    bit        mrec;

    prn_alloc_ctrl #(.N_WAY(NW), .PRF_SIZE(PS), .PRF_WIDTH(PW)) dut (
        .clock            (clock),
        .reset            (reset),
        .free_list_in     (free_list_in),
        .dispatch_req     (dispatch_req),
        .squash           (squash),
        .alloc_prn_out    (alloc_prn_out),
        .alloc_valid_out  (alloc_valid_out),
        .stall_out        (stall_out),
        .staged_count_out (staged_count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] lane(input int i);
        return alloc_prn_out[i*PW +: PW];
    endfunction

    // Drive one cycle of inputs, check outputs against the model, then advance the model.
    task automatic cycle(input bit r, input bit s, input logic [2:0] rq, input logic [63:0] fl);
        logic [2:0] eg;
        bit         est;
        bit         covered;
        int         ecnt;
        int         q[$];
        bit         held;
        bit [63:0]  nprev;
        @(negedge clock);
        reset        = r;
        squash       = s;
        dispatch_req = rq;
        free_list_in = fl;
        #1;
        covered = 1'b1;
        ecnt    = 0;
        for (int i = 0; i < NW; i++) begin
            if (rq[i] && !mvalid[i]) covered = 1'b0;
            if (mvalid[i]) ecnt++;
        end
        eg  = 3'b000;
        est = 1'b0;
        if (r || s || mrec) est = |rq;
        else if (rq == 3'b000) est = 1'b0;
        else if (covered) eg = rq;
        else est = 1'b1;
        chk("valid", alloc_valid_out, eg);
        chk("stall", stall_out, est);
        chk("count", staged_count_out, ecnt);
        for (int i = 0; i < NW; i++) chk($sformatf("prn%0d", i), lane(i), mprn[i]);
        // model next state
        if (r) begin
            for (int i = 0; i < NW; i++) begin mvalid[i] = 0; mprn[i] = 0; end
            mprev = '0;
            mrec  = 0;
        end else if (s) begin
            for (int i = 0; i < NW; i++) mvalid[i] = 0;
            mprev = '0;
            mrec  = 1;
        end else begin
            for (int p = 1; p < PS; p++) begin
                held = 0;
                for (int j = 0; j < NW; j++)
                    if (mvalid[j] && !eg[j] && mprn[j] == p) held = 1;
                if (fl[p] && !mprev[p] && !held) q.push_back(p);
            end
            nprev = '0;
            for (int j = 0; j < NW; j++) if (eg[j]) nprev[mprn[j]] = 1'b1;
            for (int i = 0; i < NW; i++) begin
                if (!mvalid[i] || eg[i]) begin
                    if (q.size() > 0) begin mprn[i] = q.pop_front(); mvalid[i] = 1; end
                    else mvalid[i] = 0;
                end
            end
            mprev = nprev;
            mrec  = 0;
        end
    endtask

    function automatic logic [63:0] rand_free();
        logic [63:0] a;
        case ($urandom_range(0, 3))
            0: a = {$urandom, $urandom} | {$urandom, $urandom};
            1: a = {$urandom, $urandom};
            2: a = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: a = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
        endcase
        return a;
    endfunction

    initial begin
        reset        = 1'b1;
        squash       = 1'b0;
        dispatch_req = 3'b000;
        free_list_in = ~64'd1;
        for (int i = 0; i < NW; i++) begin mvalid[i] = 0; mprn[i] = 0; end
        mprev = '0;
        mrec  = 0;
        repeat (2) @(posedge clock);

        // reset held: outputs quiet, stall mirrors requests
        cycle(1, 0, 3'b101, ~64'd1);
        chk("rst_stall", stall_out, 1'b1);
        chk("rst_prn", alloc_prn_out, 18'd0);
        // post-reset fill
        cycle(0, 0, 3'b000, ~64'd1);
        chk("fill_cnt0", staged_count_out, 2'd0);
        // full grant of {1,2,3}
        cycle(0, 0, 3'b111, ~64'hF);
        chk("fill_p0", lane(0), 6'd1);
        chk("fill_p1", lane(1), 6'd2);
        chk("fill_p2", lane(2), 6'd3);
        chk("full_valid", alloc_valid_out, 3'b111);
        chk("full_cnt", staged_count_out, 2'd3);
        // partial request, lane 1 only
        cycle(0, 0, 3'b010, ~64'h7F);
        chk("next_p0", lane(0), 6'd4);
        chk("next_p1", lane(1), 6'd5);
        chk("next_p2", lane(2), 6'd6);
        chk("part_valid", alloc_valid_out, 3'b010);
        // squash mid-grant
        cycle(0, 1, 3'b111, ~64'hFF);
        chk("part_p1", lane(1), 6'd7);
        chk("sq_valid", alloc_valid_out, 3'b000);
        chk("sq_stall", stall_out, 1'b1);
        // recover with only PRN 9 free
        cycle(0, 0, 3'b111, 64'd1 << 9);
        chk("rec_cnt", staged_count_out, 2'd0);
        chk("rec_stall", stall_out, 1'b1);
        // all-or-nothing stall: only slot 0 staged
        cycle(0, 0, 3'b011, 64'd1 << 9);
        chk("aon_p0", lane(0), 6'd9);
        chk("aon_valid", alloc_valid_out, 3'b000);
        chk("aon_stall", stall_out, 1'b1);
        chk("aon_cnt", staged_count_out, 2'd1);
        // rebuilt free list, grants resume
        cycle(0, 0, 3'b000, ~64'd1 & ~(64'd1 << 9));
        cycle(0, 0, 3'b111, ~64'hF & ~(64'd1 << 9));
        chk("resume_valid", alloc_valid_out, 3'b111);
        // reset together with squash
        cycle(1, 1, 3'b111, ~64'd1);
        chk("rsq_valid", alloc_valid_out, 3'b000);
        cycle(0, 0, 3'b000, ~64'd1);
        chk("rsq_cnt", staged_count_out, 2'd0);
        cycle(0, 0, 3'b001, ~64'h3);
        chk("rsq_run_grant", alloc_valid_out, 3'b001);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                  3'($urandom_range(0, 7)), rand_free());
        end
        cycle(0, 0, 3'b000, ~64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
